ser_frame_rx: RTL and testbench
===============================

// Module: ser_frame_rx
// PURPOSE
//  Single-clock serial frame receiver: the receive end of the serializer link.
//  Hunts a bit stream for a sync word, then deserializes DATA_W data bits, checks optional parity,
//  and delivers each word on a valid/ready output through a 2-entry buffer.
//  Used where the serial side is already in the system clock domain, with one bit strobe per bit.
// PARAMETERS
//  DATA_W     8      data bits per frame
//  SYNC_W     8      sync word length in bits
//  SYNC_PAT   8'hA5  sync word, MSB received first
//  PARITY_EN  1      1: one parity bit follows the data bits; 0: no parity bit
//  ODD_PARITY 0      0: even parity (XOR of data+parity == 0); 1: odd parity (== 1)
// PORTS
//  clk_i    in   1       system clock, all logic on rising edge
//  rst_i    in   1       reset, asynchronous, active-low
//  sdata_i  in   1       serial data bit
//  svalid_i in   1       bit strobe; sdata_i is sampled only when high
//  data_o   out  DATA_W  received word, MSB = first data bit received
//  perr_o   out  1       parity error flag for the word on data_o; 0 when PARITY_EN=0
//  valid_o  out  1       data_o/perr_o hold a buffered word
//  ready_i  in   1       consumer accepts the word when valid_o && ready_i
//  locked_o out  1       high while in DATA or PAR state
//  ovf_o    out  1       one-cycle pulse: completed word dropped because the buffer was full
// BEHAVIOUR
//  Reset (rst_i=0, any time): state=HUNT; sync shift reg, fill count, bit count and buffer cleared.
//   data_o=0, perr_o=0, valid_o=0, locked_o=0, ovf_o=0. A frame in progress is discarded.
//  FSM states HUNT, DATA, PAR; nothing advances in a cycle with svalid_i=0.
//  HUNT: each strobed bit shifts into the SYNC_W sync reg LSB side. Fill count saturates at SYNC_W.
//   Match = (updated reg == SYNC_PAT) && fill count reaches SYNC_W with this bit.
//   On match: go to DATA, bit count=0. Sync may appear after any number of junk bits.
//  DATA: each strobed bit shifts into the data reg MSB-first.
//   On the DATA_W-th bit: PARITY_EN=1 -> PAR; PARITY_EN=0 -> complete the frame.
//  PAR: the next strobed bit is parity.
//   perr = ^{data,parity} ^ ODD_PARITY. Complete the frame.
//  Complete: push {data,perr} into the buffer. State -> HUNT, sync reg and fill count cleared.
//   Every frame needs its own sync word; no back-to-back frames without resync.
//  Latency: word on data_o with valid_o=1 on the cycle after the final bit is sampled,
//   when the buffer was empty.
//  Buffer: 2-entry FIFO, oldest word drives data_o/perr_o; outputs registered.
//   data_o/perr_o stable while valid_o && !ready_i.
//   Pop on valid_o && ready_i.
//   Push when full with no pop that cycle: word dropped, ovf_o=1 for one cycle, contents unchanged.
//   Push when full with a pop in the same cycle: accepted, no overflow.
//   Push and pop together when 1 entry is held: occupancy stays 1, new word appears next cycle.
//   data_o holds its last value when valid_o=0.
//  locked_o = (state==DATA || state==PAR), registered with the state.
//  Width rules: bit count is $clog2(DATA_W+1) bits; fill count is $clog2(SYNC_W+1) bits.
// TESTING
//  1 Reset asserted mid-stream -> all outputs 0, state HUNT.
//    After release, 7 bits of A5 then 1 junk bit -> no lock.
//  2 Bits 1,0 then A5, then 0x3C, then parity 0 -> data_o=8'h3C, perr_o=0.
//    valid_o=1 the cycle after the parity bit; locked_o drops that same cycle.
//  3 Same frame with parity bit 1 -> data_o=8'h3C, perr_o=1.
//    With ODD_PARITY=1 and parity 1 -> perr_o=0.
//  4 ready_i=0, three frames 0x11, 0x22, 0x33 -> ovf_o pulses once, on completion of 0x33.
//    Then ready_i=1 -> 0x11 then 0x22 on consecutive cycles, then valid_o=0.
//  5 svalid_i toggled randomly (gaps of 0-5 cycles) through frame 0x96 -> same result as gapless.
//    Buffer full with pop on the completion cycle -> no ovf_o.
//  6 rst_i low during DATA after 4 bits -> locked_o=0, no word emitted.
//    A following full frame 0x5A is received correctly.

Source files
------------

// File: rtl/ser_frame_rx.sv
// Serial frame receiver: hunts for a sync word, deserializes one data word plus
// optional parity, and hands words out through a 2-entry valid/ready buffer.
module ser_frame_rx #(
  parameter int                DATA_W     = 8,
  parameter int                SYNC_W     = 8,
  parameter logic [SYNC_W-1:0] SYNC_PAT   = 8'hA5,
  parameter bit                PARITY_EN  = 1'b1,
  parameter bit                ODD_PARITY = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sdata_i,
  input  logic              svalid_i,
  output logic [DATA_W-1:0] data_o,
  output logic              perr_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              locked_o,
  output logic              ovf_o
);

  // state | meaning
  // HUNT  | shifting strobed bits through the sync reg looking for SYNC_PAT
  // DATA  | collecting DATA_W data bits, MSB first
  // PAR   | waiting for the parity bit
  typedef enum logic [1:0] {ST_HUNT, ST_DATA, ST_PAR} state_t;

  localparam int FW = $clog2(SYNC_W + 1);
  localparam int BW = $clog2(DATA_W + 1);

  state_t              state_q, state_d;
  logic [SYNC_W-1:0]   sync_q, sync_d;
  logic [FW-1:0]       fill_q, fill_d;
  logic [BW-1:0]       bcnt_q, bcnt_d;
  logic [DATA_W-1:0]   shft_q, shft_d;
  logic                locked_q, locked_d;

  logic [SYNC_W-1:0]   sync_shift;
  logic [FW-1:0]       fill_inc;
  logic [DATA_W-1:0]   data_shift;
  logic                done;
  logic [DATA_W-1:0]   done_data;
  logic                done_perr;

  logic [1:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_perr_q, out_perr_d;
  logic [DATA_W-1:0]   e1_data_q, e1_data_d;
  logic                e1_perr_q, e1_perr_d;
  logic                ovf_q, ovf_d;
  logic                pop;

  always_comb begin
    sync_shift = SYNC_W'({sync_q, sdata_i});
    data_shift = DATA_W'({shft_q, sdata_i});
    fill_inc   = (fill_q == FW'(SYNC_W)) ? fill_q : fill_q + FW'(1);

    state_d   = state_q;
    sync_d    = sync_q;
    fill_d    = fill_q;
    bcnt_d    = bcnt_q;
    shft_d    = shft_q;
    done      = 1'b0;
    done_data = shft_q;
    done_perr = 1'b0;

    if (svalid_i) begin
      case (state_q)
        ST_HUNT: begin
          sync_d = sync_shift;
          fill_d = fill_inc;
          if ((sync_shift == SYNC_PAT) && (fill_inc == FW'(SYNC_W))) begin
            state_d = ST_DATA;
            bcnt_d  = '0;
          end
        end
        ST_DATA: begin
          shft_d = data_shift;
          bcnt_d = bcnt_q + BW'(1);
          if (bcnt_q == BW'(DATA_W - 1)) begin
            if (PARITY_EN) begin
              state_d = ST_PAR;
            end else begin
              done      = 1'b1;
              done_data = data_shift;
              state_d   = ST_HUNT;
              sync_d    = '0;
              fill_d    = '0;
            end
          end
        end
        ST_PAR: begin
          done      = 1'b1;
          done_data = shft_q;
          done_perr = (^{shft_q, sdata_i}) ^ ODD_PARITY;
          state_d   = ST_HUNT;
          sync_d    = '0;
          fill_d    = '0;
        end
        default: begin
          state_d = ST_HUNT;
          sync_d  = '0;
          fill_d  = '0;
        end
      endcase
    end

    locked_d = (state_d == ST_DATA) || (state_d == ST_PAR);
  end

  // Head entry lives directly in the output registers; e1 is the second slot.
  always_comb begin
    pop        = (cnt_q != 2'd0) && ready_i;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_perr_d = out_perr_q;
    e1_data_d  = e1_data_q;
    e1_perr_d  = e1_perr_q;
    ovf_d      = 1'b0;

    case (cnt_q)
      2'd0: begin
        if (done) begin
          out_data_d = done_data;
          out_perr_d = done_perr;
          cnt_d      = 2'd1;
        end
      end
      2'd1: begin
        if (done && pop) begin
          out_data_d = done_data;
          out_perr_d = done_perr;
        end else if (done) begin
          e1_data_d = done_data;
          e1_perr_d = done_perr;
          cnt_d     = 2'd2;
        end else if (pop) begin
          cnt_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          out_data_d = e1_data_q;
          out_perr_d = e1_perr_q;
          if (done) begin
            e1_data_d = done_data;
            e1_perr_d = done_perr;
          end else begin
            cnt_d = 2'd1;
          end
        end else if (done) begin
          ovf_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_HUNT;
      sync_q     <= '0;
      fill_q     <= '0;
      bcnt_q     <= '0;
      shft_q     <= '0;
      locked_q   <= 1'b0;
      cnt_q      <= 2'd0;
      out_data_q <= '0;
      out_perr_q <= 1'b0;
      e1_data_q  <= '0;
      e1_perr_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      fill_q     <= fill_d;
      bcnt_q     <= bcnt_d;
      shft_q     <= shft_d;
      locked_q   <= locked_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_perr_q <= out_perr_d;
      e1_data_q  <= e1_data_d;
      e1_perr_q  <= e1_perr_d;
      ovf_q      <= ovf_d;
    end
  end

  assign data_o   = out_data_q;
  assign perr_o   = out_perr_q;
  assign valid_o  = (cnt_q != 2'd0);
  assign locked_o = locked_q;
  assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_ser_frame_rx.sv
// Scoreboard bench for ser_frame_rx: an even-parity and an odd-parity instance
// share one stimulus stream; a monitor pops expected words as the DUTs deliver them.
module tb_ser_frame_rx;
  logic       clk = 1'b0;
  logic       rst_n, sdata, svalid, ready;
  logic [7:0] data_e, data_o_odd;
  logic       perr_e, valid_e, locked_e, ovf_e;
  logic       perr_od, valid_od, locked_od, ovf_od;

  int checks = 0;
  int failures = 0;
  int ovf_cnt_e = 0;
  int ovf_cnt_o = 0;
  logic [8:0] q_even[$];
  logic [8:0] q_odd[$];

  always #5 clk = ~clk;

  ser_frame_rx u_even (
    .clk_i(clk), .rst_i(rst_n), .sdata_i(sdata), .svalid_i(svalid),
    .data_o(data_e), .perr_o(perr_e), .valid_o(valid_e), .ready_i(ready),
    .locked_o(locked_e), .ovf_o(ovf_e));

  ser_frame_rx #(.ODD_PARITY(1'b1)) u_odd (
    .clk_i(clk), .rst_i(rst_n), .sdata_i(sdata), .svalid_i(svalid),
    .data_o(data_o_odd), .perr_o(perr_od), .valid_o(valid_od), .ready_i(ready),
    .locked_o(locked_od), .ovf_o(ovf_od));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every accepted word against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_e && ready) begin
        if (q_even.size() == 0) chk("even_unexpected_word", {23'd0, data_e, perr_e}, 32'h1FF);
        else chk("even_word", {23'd0, data_e, perr_e}, {23'd0, q_even.pop_front()});
      end
      if (valid_od && ready) begin
        if (q_odd.size() == 0) chk("odd_unexpected_word", {23'd0, data_o_odd, perr_od}, 32'h1FF);
        else chk("odd_word", {23'd0, data_o_odd, perr_od}, {23'd0, q_odd.pop_front()});
      end
      if (ovf_e) ovf_cnt_e++;
      if (ovf_od) ovf_cnt_o++;
    end
  end

  task automatic expect_word(input logic [7:0] d, input logic perr_even);
    q_even.push_back({d, perr_even});
    q_odd.push_back({d, ~perr_even});
  endtask

  task automatic send_bit(input logic b, input int gap);
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
    end
    sdata = b; svalid = 1'b1;
    @(posedge clk); #1;
    svalid = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] v, input int n, input int maxgap);
    for (int i = n - 1; i >= 0; i--)
      send_bit(v[i], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input int maxgap,
                            input logic rdy_last);
    send_bits(16'h00A5, 8, maxgap);
    send_bits({8'h00, d}, 8, maxgap);
    for (int g = 0; g < ((maxgap == 0) ? 0 : int'($urandom_range(0, maxgap))); g++) begin
      @(posedge clk); #1;
    end
    if (rdy_last) ready = 1'b1;
    send_bit(par, 0);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((q_even.size() != 0 || valid_e) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, q_even.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sdata = 1'b0; svalid = 1'b0; ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", valid_e, 0);
    chk("rst_data", data_e, 0);
    chk("rst_locked", locked_e, 0);
    chk("rst_ovf", ovf_e, 0);
    chk("rst_perr", perr_e, 0);
    rst_n = 1'b1;

    // 1: reset mid-frame, then 7 sync bits plus a junk bit must not lock
    send_bits(16'h00A5, 8, 0);
    send_bits(16'h0005, 3, 0);
    chk("t1_locked_mid", locked_e, 1);
    rst_n = 1'b0;
    #2;
    chk("t1_rst_locked", locked_e, 0);
    chk("t1_rst_valid", valid_e, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_bits(16'h0052, 7, 0);
    send_bit(1'b0, 0);
    @(posedge clk); #1;
    chk("t1_no_lock", locked_e, 0);
    chk("t1_no_word", valid_e, 0);

    // 2: junk 1,0 then sync, 0x3C, even parity bit 0
    send_bits(16'h0002, 2, 0);
    send_bits(16'h00A5, 8, 0);
    send_bits(16'h003C, 8, 0);
    chk("t2_locked_par", locked_e, 1);
    chk("t2_valid_before", valid_e, 0);
    expect_word(8'h3C, 1'b0);
    send_bit(1'b0, 0);
    chk("t2_valid", valid_e, 1);
    chk("t2_data", data_e, 8'h3C);
    chk("t2_perr", perr_e, 0);
    chk("t2_unlock", locked_e, 0);
    drain("t2_drain");

    // 3: same frame, parity bit 1
    expect_word(8'h3C, 1'b1);
    send_frame(8'h3C, 1'b1, 0, 1'b0);
    chk("t3_perr_even", perr_e, 1);
    chk("t3_perr_odd", perr_od, 0);
    drain("t3_drain");

    // 4: fill the buffer with ready low, third frame overflows
    ready = 1'b0;
    expect_word(8'h11, 1'b0);
    send_frame(8'h11, 1'b0, 0, 1'b0);
    expect_word(8'h22, 1'b0);
    send_frame(8'h22, 1'b0, 0, 1'b0);
    chk("t4_no_ovf_yet", ovf_e, 0);
    send_frame(8'h33, 1'b0, 0, 1'b0);
    chk("t4_ovf", ovf_e, 1);
    @(posedge clk); #1;
    chk("t4_ovf_pulse", ovf_e, 0);
    chk("t4_hold", data_e, 8'h11);
    ready = 1'b1;
    @(posedge clk); #1;
    chk("t4_second", {valid_e, data_e}, {1'b1, 8'h22});
    @(posedge clk); #1;
    chk("t4_empty", valid_e, 0);

    // 5: gapless and gapped 0x96, then full buffer popped on the completion cycle
    expect_word(8'h96, 1'b0);
    send_frame(8'h96, 1'b0, 0, 1'b0);
    drain("t5_gapless");
    expect_word(8'h96, 1'b0);
    send_frame(8'h96, 1'b0, 5, 1'b0);
    drain("t5_gapped");
    ready = 1'b0;
    expect_word(8'h0F, 1'b0);
    send_frame(8'h0F, 1'b0, 0, 1'b0);
    expect_word(8'hF0, 1'b0);
    send_frame(8'hF0, 1'b0, 0, 1'b0);
    expect_word(8'h96, 1'b1);
    send_frame(8'h96, 1'b1, 5, 1'b1);
    chk("t5_no_ovf", ovf_e, 0);
    drain("t5_drain");

    // 6: reset after 4 data bits, then a clean 0x5A frame
    send_bits(16'h00A5, 8, 0);
    send_bits(16'h0005, 4, 0);
    chk("t6_locked", locked_e, 1);
    rst_n = 1'b0;
    #2;
    chk("t6_rst_locked", locked_e, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t6_no_word", valid_e, 0);
    expect_word(8'h5A, 1'b1);
    send_frame(8'h5A, 1'b1, 0, 1'b0);
    chk("t6_data", data_e, 8'h5A);
    drain("t6_drain");

    chk("ovf_total_even", ovf_cnt_e, 1);
    chk("ovf_total_odd", ovf_cnt_o, 1);
    chk("odd_queue_empty", q_odd.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
